// File: rtl/sram_ctrl.sv
// Single-port controller for one asynchronous SRAM chip.
// It takes one word request at a time, sequences the ce_n/oe_n/we_n pins, and returns read data or a write acknowledge.
module sram_ctrl #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    input  logic [31:0]       ram_data_i
);

    localparam int unsigned MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [3:0]         ram_be_n_q, ram_be_n_d;
    logic               ram_ce_n_q, ram_ce_n_d;
    logic               ram_oe_n_q, ram_oe_n_d;
    logic               ram_we_n_q, ram_we_n_d;
    logic [31:0]        ram_data_o_q, ram_data_o_d;
    logic               ram_data_oe_q, ram_data_oe_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;

    // Byte-offset and upper address bits do not select an SRAM word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_be_n    = ram_be_n_q;
    assign ram_ce_n    = ram_ce_n_q;
    assign ram_oe_n    = ram_oe_n_q;
    assign ram_we_n    = ram_we_n_q;
    assign ram_data_o  = ram_data_o_q;
    assign ram_data_oe = ram_data_oe_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ram_addr_q    <= '0;
            ram_be_n_q    <= 4'hF;
            ram_ce_n_q    <= 1'b1;
            ram_oe_n_q    <= 1'b1;
            ram_we_n_q    <= 1'b1;
            ram_data_o_q  <= '0;
            ram_data_oe_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_be_n_q    <= ram_be_n_d;
            ram_ce_n_q    <= ram_ce_n_d;
            ram_oe_n_q    <= ram_oe_n_d;
            ram_we_n_q    <= ram_we_n_d;
            ram_data_o_q  <= ram_data_o_d;
            ram_data_oe_q <= ram_data_oe_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    // Next-state logic; the pin values computed here appear one cycle later.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_be_n_d    = ram_be_n_q;
        ram_ce_n_d    = ram_ce_n_q;
        ram_oe_n_d    = ram_oe_n_q;
        ram_we_n_d    = ram_we_n_q;
        ram_data_o_d  = ram_data_o_q;
        ram_data_oe_d = ram_data_oe_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;

        unique case (state_q)
            IDLE: begin
                ram_ce_n_d    = 1'b1;
                ram_oe_n_d    = 1'b1;
                ram_we_n_d    = 1'b1;
                ram_be_n_d    = 4'hF;
                ram_data_oe_d = 1'b0;
                if (req_valid) begin
                    if (!req_we) begin
                        state_d    = RD;
                        ram_ce_n_d = 1'b0;
                        ram_oe_n_d = 1'b0;
                        ram_be_n_d = 4'h0;
                        ram_addr_d = req_addr[ADDR_W+1:2];
                        cnt_d      = CNT_W'(READ_WAIT - 1);
                    end else if (req_be != 4'h0) begin
                        state_d       = WR_SETUP;
                        ram_ce_n_d    = 1'b0;
                        ram_be_n_d    = ~req_be;
                        ram_addr_d    = req_addr[ADDR_W+1:2];
                        ram_data_o_d  = req_wdata;
                        ram_data_oe_d = 1'b1;
                    end else begin
                        // A write with no enabled bytes is acknowledged without touching the chip.
                        resp_valid_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ram_data_i;
                    ram_ce_n_d   = 1'b1;
                    ram_oe_n_d   = 1'b1;
                    ram_be_n_d   = 4'hF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d    = WR_PULSE;
                ram_we_n_d = 1'b0;
                cnt_d      = CNT_W'(WRITE_WAIT - 1);
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d    = WR_HOLD;
                    ram_we_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_d       = IDLE;
                resp_valid_d  = 1'b1;
                ram_ce_n_d    = 1'b1;
                ram_be_n_d    = 4'hF;
                ram_data_oe_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Single-port controller for one external asynchronous SRAM chip (BaseRAM or ExtRAM). It sits directly downstream of the instruction/data arbiter (z_stage).
- Accepts one word request at a time over a valid/ready handshake.
- Sequences the chip-enable, output-enable and write-enable pins with fixed, parameterised timing, then returns read data or a write acknowledgement.
- The top level instantiates one controller per chip.

Parameters:
- ADDR_W, 20, SRAM word-address width. Word address is req_addr[ADDR_W+1:2].
- READ_WAIT, 2, number of cycles the read access is held on the pins. Must be ≥1.
- WRITE_WAIT, 2, width in cycles of the we_n low pulse. Must be ≥1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables for writes (bit i = byte i). Ignored on reads.
- req_addr  in  32  byte address. Bits [1:0] are ignored.
- req_wdata  in  32  write data.
- resp_valid  out  1  one-cycle pulse: read data valid or write complete.
- resp_rdata  out  32  read data. Only meaningful when resp_valid=1 and the request was a read.
- ram_addr  out  ADDR_W  SRAM address pins.
- ram_be_n  out  4  SRAM byte enables, active low.
- ram_ce_n  out  1  chip enable, active low.
- ram_oe_n  out  1  output enable, active low.
- ram_we_n  out  1  write enable, active low.
- ram_data_o  out  32  data driven toward the SRAM.
- ram_data_oe  out  1  1 = top-level tristate drives ram_data_o onto the bus.
- ram_data_i  in  32  data sampled from the SRAM bus.

Behaviour:
- Signal timing:
  - All ram_* outputs and resp_* outputs are registered.
  - req_ready is combinational: req_ready = (state==IDLE).
- Reset (asynchronous, resetn=0), taking effect immediately regardless of state:
  - state=IDLE.
  - ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_be_n=4'hF.
  - ram_data_oe=0, ram_addr=0, ram_data_o=0.
  - resp_valid=0, resp_rdata=0, wait counter=0.
  - Any in-flight request is dropped with no response. A write aborted mid-pulse may leave the SRAM word undefined.
- Handshake:
  - A request is accepted on a cycle with req_valid && req_ready.
  - On acceptance, addr, we, be and wdata are latched. Later changes to req_* have no effect until the controller returns to IDLE.
- Counter: the wait counter width is clog2(max(READ_WAIT, WRITE_WAIT)+1).
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - All ram controls are inactive (same values as reset) and ram_data_oe=0.
  - Read accept → RD: ce_n=0, oe_n=0, be_n=0000, addr driven, counter=READ_WAIT-1.
  - Write accept with req_be≠0 → WR_SETUP: ce_n=0, oe_n=1, we_n=1, be_n=~req_be, data_oe=1, data_o=wdata.
  - Write accept with req_be==0 → stay in IDLE. resp_valid=1 the next cycle. No pins toggle.
- RD:
  - Held for READ_WAIT cycles (counter decrements).
  - On the edge ending the last RD cycle: resp_rdata ← ram_data_i, resp_valid ← 1, controls released, state → IDLE.
- WR_SETUP: 1 cycle, then → WR_PULSE with we_n=0 and counter=WRITE_WAIT-1.
- WR_PULSE: held for WRITE_WAIT cycles, then → WR_HOLD with we_n=1. ce_n, addr and data are held.
- WR_HOLD: 1 cycle, then → IDLE. Controls released, data_oe=0, resp_valid=1, resp_rdata unchanged.
- Latency, with acceptance in cycle T:
  - Read: pins active in T+1..T+READ_WAIT; resp_valid in T+READ_WAIT+1.
  - Write: resp_valid in T+WRITE_WAIT+3.
- Back-to-back: req_ready=1 in the same cycle that resp_valid=1, so a new request may be accepted in the response cycle.
- resp_valid lasts exactly one cycle. There is no response backpressure; the consumer must take it.
- Bus contention rules:
  - ram_oe_n=0 and ram_data_oe=1 are never asserted in the same cycle.
  - ram_we_n=0 only occurs while ram_ce_n=0 and ram_data_oe=1.
  - Address and data are stable for the whole span from WR_SETUP through WR_HOLD.

Test Plan:
- Reset values: hold resetn=0 across arbitrary inputs → ce_n/oe_n/we_n=1, be_n=F, data_oe=0, resp_valid=0, req_ready=1. Deassert reset → stays in IDLE.
- Single read: read of addr 0x0000_0010 with ram_data_i=0xDEADBEEF, accepted at T → ram_addr=4 and oe_n=0 in T+1..T+2; resp_valid=1 with rdata 0xDEADBEEF at T+3 only.
- Single write: write of addr 0x0000_0020, wdata 0x12345678, be=0101, accepted at T → addr=8 and be_n=1010 from T+1..T+4; we_n=0 exactly in T+2..T+3; data_oe=1 in T+1..T+4; resp_valid at T+5.
- Back-to-back: write accepted in the resp_valid cycle of a preceding read → no idle gap; the read rdata is preserved; oe_n and data_oe never overlap.
- Zero byte enable: write with be=0000 → no ce_n/we_n activity; resp_valid the next cycle.
- Reset mid-operation: resetn=0 asynchronously during WR_PULSE → we_n=1 and data_oe=0 immediately (same cycle, no clock edge needed); no resp_valid after release; the next read completes normally.
